// File: rtl/ether_rx_if.sv
// RMII receive dibit stream in, payload dibit stream out toward the checksum stage.
interface ether_rx_if;
  logic       crsdv;
  logic [1:0] rxd;
  logic       axiov;
  logic [1:0] axiod;

  modport master (input crsdv, rxd, output axiov, axiod);
  modport slave  (output crsdv, rxd, input axiov, axiod);
endinterface

// File: rtl/ether_rx.sv
// RMII receive framer: strips preamble/SFD and forwards payload dibits with 1-cycle latency.
// Optional frame/error statistics counters are compiled in with ETHER_RX_STATS_EN.
module ether_rx #(
  parameter int MIN_PREAMBLE = 28
) (
  input  logic          clk,
  input  logic          rst,
  ether_rx_if.master    bus
`ifdef ETHER_RX_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t     state;
  logic [5:0] pre_cnt;
  logic       axiov_q;
  logic [1:0] axiod_q;
  logic       pre_ok;

  assign pre_ok    = int'(pre_cnt) >= MIN_PREAMBLE;
  assign bus.axiov = axiov_q;
  assign bus.axiod = axiod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DROP;
      pre_cnt <= 6'd0;
      axiov_q <= 1'b0;
      axiod_q <= 2'b00;
`ifdef ETHER_RX_STATS_EN
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
`endif
    end else begin
      axiov_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.crsdv) begin
            if (bus.rxd == 2'b01) begin
              state   <= PREAMBLE;
              pre_cnt <= 6'd1;
            end else if (bus.rxd[1]) begin
              state <= DROP;
`ifdef ETHER_RX_STATS_EN
              err_cnt <= err_cnt + 16'd1;
`endif
            end
          end
        end
        PREAMBLE: begin
          if (!bus.crsdv) begin
            state <= IDLE;
          end else if (bus.rxd == 2'b01) begin
            if (pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;
          end else if (bus.rxd == 2'b11 && pre_ok) begin
            state <= DATA;
          end else begin
            // short preamble before SFD, or a 00/10 dibit inside the preamble
            state <= DROP;
`ifdef ETHER_RX_STATS_EN
            err_cnt <= err_cnt + 16'd1;
`endif
          end
        end
        DATA: begin
          axiov_q <= bus.crsdv;
          if (bus.crsdv) begin
            axiod_q <= bus.rxd;
          end else begin
            state <= IDLE;
`ifdef ETHER_RX_STATS_EN
            frame_cnt <= frame_cnt + 16'd1;
`endif
          end
        end
        DROP: begin
          if (!bus.crsdv) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ether_rx.sv
// Directed vector bench for ether_rx; statistics checks are active when ETHER_RX_STATS_EN is defined.
module tb_ether_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  ether_rx_if bus();
`ifdef ETHER_RX_STATS_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  ether_rx #(.MIN_PREAMBLE(28)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ETHER_RX_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    bit         c;
    logic [1:0] d;
    bit         ev;
    logic [1:0] ed;
    bit         chk;
    int         ef;
    int         ee;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input bit r, input bit c, input logic [1:0] d, input bit ev, input logic [1:0] ed);
    vec_t v;
    v.r = r; v.c = c; v.d = d; v.ev = ev; v.ed = ed; v.chk = 1'b0; v.ef = 0; v.ee = 0;
    tbl.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [1:0] d, input logic [1:0] ed);
    for (int i = 0; i < n; i++) add(1'b0, 1'b1, d, 1'b0, ed);
  endtask

  task automatic stat(input int f, input int e);
    tbl[tbl.size()-1].chk = 1'b1;
    tbl[tbl.size()-1].ef  = f;
    tbl[tbl.size()-1].ee  = e;
  endtask

  task automatic check_stats(input int f, input int e, input string nm);
`ifdef ETHER_RX_STATS_EN
    checks++;
    if (frame_cnt !== 16'(f)) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d exp %0d", nm, frame_cnt, f);
    end
    checks++;
    if (err_cnt !== 16'(e)) begin
      errors++;
      $display("FAIL %s err_cnt got %0d exp %0d", nm, err_cnt, e);
    end
`endif
  endtask

  task automatic step(input bit r, input bit c, input logic [1:0] d, input bit ev, input logic [1:0] ed, input string nm);
    @(negedge clk);
    rst = r; bus.crsdv = c; bus.rxd = d;
    @(posedge clk);
    #1;
    checks++;
    if (bus.axiov !== ev) begin
      errors++;
      $display("FAIL %s axiov got %b exp %b", nm, bus.axiov, ev);
    end
    checks++;
    if (bus.axiod !== ed) begin
      errors++;
      $display("FAIL %s axiod got %b exp %b", nm, bus.axiod, ed);
    end
  endtask

  initial begin
    logic [1:0] pay[8];
    pay = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    bus.crsdv = 1'b0;
    bus.rxd   = 2'b00;

    // reset, then DROP -> IDLE on idle carrier
    add(1, 0, 2'b00, 0, 2'b00);
    add(1, 1, 2'b11, 0, 2'b00);
    add(0, 0, 2'b10, 0, 2'b00); stat(0, 0);
    // valid frame, 31 preamble dibits
    add_n(31, 2'b01, 2'b00);
    add(0, 1, 2'b11, 0, 2'b00);
    for (int i = 0; i < 8; i++) add(0, 1, pay[i], 1, pay[i]);
    add(0, 0, 2'b10, 0, 2'b00);
    add(0, 0, 2'b11, 0, 2'b00); stat(1, 0);
    // short preamble
    add_n(20, 2'b01, 2'b00);
    add(0, 1, 2'b11, 0, 2'b00);
    add_n(3, 2'b01, 2'b00);
    add(0, 0, 2'b10, 0, 2'b00); stat(1, 1);
    // corrupt preamble
    add_n(10, 2'b01, 2'b00);
    add(0, 1, 2'b10, 0, 2'b00);
    add_n(21, 2'b01, 2'b00);
    add(0, 1, 2'b11, 0, 2'b00);
    add_n(4, 2'b11, 2'b00);
    add(0, 0, 2'b00, 0, 2'b00); stat(1, 2);
    // leading zeros, preamble exactly at minimum
    add_n(5, 2'b00, 2'b00);
    add_n(28, 2'b01, 2'b00);
    add(0, 1, 2'b11, 0, 2'b00);
    add(0, 1, 2'b11, 1, 2'b11);
    add(0, 1, 2'b01, 1, 2'b01);
    add(0, 1, 2'b10, 1, 2'b10);
    add(0, 0, 2'b01, 0, 2'b10); stat(2, 2);
    // one dibit short of minimum
    add_n(27, 2'b01, 2'b10);
    add(0, 1, 2'b11, 0, 2'b10);
    add(0, 1, 2'b01, 0, 2'b10);
    add(0, 0, 2'b00, 0, 2'b10); stat(2, 3);
    // back-to-back frames with a single idle cycle
    add_n(28, 2'b01, 2'b10);
    add(0, 1, 2'b11, 0, 2'b10);
    add(0, 1, 2'b01, 1, 2'b01);
    add(0, 1, 2'b10, 1, 2'b10);
    add(0, 0, 2'b00, 0, 2'b10);
    add_n(28, 2'b01, 2'b10);
    add(0, 1, 2'b11, 0, 2'b10);
    add(0, 1, 2'b11, 1, 2'b11);
    add(0, 1, 2'b00, 1, 2'b00);
    add(0, 0, 2'b11, 0, 2'b00); stat(4, 3);
    // bad first dibit from IDLE
    add(0, 1, 2'b10, 0, 2'b00);
    add(0, 1, 2'b01, 0, 2'b00);
    add(0, 0, 2'b00, 0, 2'b00); stat(4, 4);
    // SFD then immediate end of carrier
    add_n(30, 2'b01, 2'b00);
    add(0, 1, 2'b11, 0, 2'b00);
    add(0, 0, 2'b10, 0, 2'b00); stat(5, 4);
    // long preamble saturates the counter and is still accepted
    add_n(70, 2'b01, 2'b00);
    add(0, 1, 2'b11, 0, 2'b00);
    add(0, 1, 2'b11, 1, 2'b11);
    add(0, 0, 2'b00, 0, 2'b11); stat(6, 4);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].d, tbl[i].ev, tbl[i].ed, $sformatf("vec%0d", i));
      if (tbl[i].chk) check_stats(tbl[i].ef, tbl[i].ee, $sformatf("stat%0d", i));
    end

    // reset pulsed on the 4th payload dibit while carrier stays up
    for (int i = 0; i < 28; i++) step(0, 1, 2'b01, 0, 2'b11, "rstmid_pre");
    step(0, 1, 2'b11, 0, 2'b11, "rstmid_sfd");
    step(0, 1, 2'b10, 1, 2'b10, "rstmid_p1");
    step(0, 1, 2'b01, 1, 2'b01, "rstmid_p2");
    step(0, 1, 2'b11, 1, 2'b11, "rstmid_p3");
    step(1, 1, 2'b00, 0, 2'b00, "rstmid_p4");
    step(0, 1, 2'b10, 0, 2'b00, "rstmid_p5");
    step(0, 1, 2'b11, 0, 2'b00, "rstmid_p6");
    step(0, 0, 2'b00, 0, 2'b00, "rstmid_end");
    check_stats(0, 0, "rstmid_stat");
    for (int i = 0; i < 28; i++) step(0, 1, 2'b01, 0, 2'b00, "after_pre");
    step(0, 1, 2'b11, 0, 2'b00, "after_sfd");
    step(0, 1, 2'b01, 1, 2'b01, "after_p1");
    step(0, 1, 2'b11, 1, 2'b11, "after_p2");
    step(0, 0, 2'b10, 0, 2'b11, "after_end");
    check_stats(1, 0, "after_stat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ether_rx.md
ETHER_RX -- requirements
Module: ether_rx

Interface
REQ-001 SHALL have parameter MIN_PREAMBLE, default 28, which is the minimum number of consecutive 01 preamble dibits required before the SFD dibit.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port crsdv, input, 1 bit: RMII carrier-sense/data-valid.
REQ-005 SHALL have port rxd, input, 2 bits: RMII receive dibit, LSB-first per byte.
REQ-006 SHALL have port axiov, output, 1 bit: payload dibit valid; it drives the downstream checksum stage's axiiv.
REQ-007 SHALL have port axiod, output, 2 bits: payload dibit, with preamble and SFD stripped.
REQ-008 SHALL have port frame_cnt, output, 16 bits, present only with ETHER_RX_STATS_EN.
REQ-009 SHALL have port err_cnt, output, 16 bits, present only with ETHER_RX_STATS_EN.

Function
REQ-010 SHALL implement the FSM states IDLE, PREAMBLE, DATA and DROP, plus a 6-bit preamble counter pre_cnt that saturates at 63.
REQ-011 In IDLE, SHALL behave as follows:
- crsdv=0 or rxd=00: stay in IDLE.
- crsdv=1 and rxd=01: go to PREAMBLE with pre_cnt=1.
- crsdv=1 and rxd=10 or 11: go to DROP.
REQ-012 In PREAMBLE, SHALL behave as follows:
- crsdv=0: go to IDLE.
- rxd=01: increment pre_cnt.
- rxd=11 and pre_cnt>=MIN_PREAMBLE: go to DATA.
- rxd=11 and pre_cnt<MIN_PREAMBLE: go to DROP.
- rxd=00 or 10: go to DROP.
REQ-013 In DATA, SHALL register crsdv into axiov and rxd into axiod each cycle; crsdv=0 SHALL move the FSM to IDLE.
REQ-014 In DROP, SHALL hold axiov=0 and stay until crsdv=0, then go to IDLE.
REQ-015 The SFD dibit (11) SHALL NOT be forwarded; the first forwarded dibit is the one on the cycle after the SFD.
REQ-016 Latency SHALL be exactly 1 cycle from an rxd sample to the matching axiod/axiov.
REQ-017 axiov SHALL be high only while in DATA; it SHALL fall on the cycle after crsdv is first sampled low, with no gaps inside a frame.
REQ-018 axiod SHALL hold its last value whenever axiov=0; downstream SHALL ignore it then.
REQ-019 An SFD followed immediately by crsdv=0 SHALL produce zero valid cycles and still return the FSM to IDLE.
REQ-020 Back-to-back frames separated by a single crsdv=0 cycle SHALL both be accepted.
REQ-021 No RMII CRS_DV toggle recovery is provided; the first crsdv=0 sample ends the frame.

Reset
REQ-022 On rst=1 the block SHALL set axiov=0, axiod=00, pre_cnt=0 and the FSM state to DROP.
REQ-023 Entering DROP from reset SHALL NOT increment err_cnt.
REQ-024 Reset mid-frame SHALL drive axiov=0 on the next cycle and discard the remainder of the frame until crsdv is sampled 0.
REQ-025 With ETHER_RX_STATS_EN, rst SHALL clear frame_cnt and err_cnt to 0.

Configuration
REQ-026 SHALL use the macro ETHER_RX_STATS_EN to compile the statistics feature in or out.
REQ-027 With ETHER_RX_STATS_EN defined, the counters SHALL update as follows:
- frame_cnt increments on every DATA->IDLE transition.
- err_cnt increments on every IDLE->DROP or PREAMBLE->DROP transition.
- Both counters wrap from 16'hFFFF to 0.
REQ-028 With ETHER_RX_STATS_EN undefined, frame_cnt, err_cnt and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario, valid frame: crsdv=1 with 31x01, then 11, then 8 payload dibits 00,01,10,11,11,10,01,00, then crsdv=0. Required: axiov high for exactly 8 cycles, axiod equals the payload delayed 1 cycle, frame_cnt=1.
REQ-030 Scenario, short preamble: 20x01 then 11 with MIN_PREAMBLE=28. Required: axiov never high, err_cnt=1, FSM back in IDLE after crsdv=0.
REQ-031 Scenario, corrupt preamble: 10x01, then 10, then 21x01, then 11, then payload. Required: whole frame dropped, axiov=0 throughout, err_cnt=1.
REQ-032 Scenario, reset mid-frame: rst pulsed 1 cycle during the 4th payload dibit while crsdv stays 1. Required: axiov=0 from the next cycle to the end of carrier, err_cnt unchanged; a following valid frame is forwarded normally.
REQ-033 Scenario, back-to-back frames: two valid frames separated by 1 idle cycle. Required: both forwarded, separated by an axiov-low gap of at least 1 cycle, frame_cnt=2.
REQ-034 Scenario, leading zeros: crsdv=1 with 5x00 before a valid preamble/SFD. Required: frame accepted, first valid axiod equals the first payload dibit.
